i2c_target_rx: RTL and testbench

- I2C target (responder) for the SoC's I2C display link; the far end of the GPU's SCL/SDA master interface.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs it.
- Deserialises write bytes into a single-cycle valid stream.
- Used as an on-chip display/loopback model and as a second board receiving frames from another SoC.

---
 rtl/i2c_target_rx_pkg.sv | 29 ++
 rtl/i2c_target_rx_line_sync.sv | 68 ++++++
 rtl/i2c_target_rx.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : I2cTargetPackage
// Description : Shared types and constants for the I2C target receiver.
//               State encoding for the protocol FSM, the R/W bit value
//               and the byte geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package I2cTargetPackage;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR       = 3'd1,
        ADDR_ACK   = 3'd2,
        WRITE_BYTE = 3'd3,
        WRITE_ACK  = 3'd4,
        READ_BYTE  = 3'd5,
        READ_ACK   = 3'd6,
        IGNORE     = 3'd7
    } I2cTargetState_enum;

    localparam logic       I2C_RW_READ       = 1'b1;
    localparam int         I2C_BITS_PER_BYTE = 8;
    // Bit-counter value seen while the last bit of a byte is being handled.
    localparam logic [2:0] LAST_BIT_IDX      = 3'(I2C_BITS_PER_BYTE - 1);

endpackage
`default_nettype wire

// File: rtl/i2c_target_rx_line_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : Synchronises the raw SCL/SDA pins into the clk domain and
//               derives edge strobes plus START/STOP conditions.
// Ports       : clk, reset    - system clock, async active-high reset
//               scl_in/sda_in - raw pin levels
//               scl_hi/sda_hi - synchronised line levels
//               scl_rise/scl_fall - one-cycle SCL edge strobes
//               start_det/stop_det - SDA fall/rise while SCL is high
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_hi,
    output logic sda_hi,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // Depths below two are not metastability safe; clamp rather than fail.
    localparam int EFF_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [EFF_STAGES-1:0] scl_sync_q;
    logic [EFF_STAGES-1:0] sda_sync_q;
    logic                  scl_prev_q;
    logic                  sda_prev_q;

    // Idle bus level is high, so resetting to 1 cannot fake an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[EFF_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[EFF_STAGES-2:0], sda_in};
            scl_prev_q <= scl_sync_q[EFF_STAGES-1];
            sda_prev_q <= sda_sync_q[EFF_STAGES-1];
        end
    end

    logic w_scl_cur;
    logic w_sda_cur;

    assign w_scl_cur = scl_sync_q[EFF_STAGES-1];
    assign w_sda_cur = sda_sync_q[EFF_STAGES-1];

    assign scl_hi    = w_scl_cur;
    assign sda_hi    = w_sda_cur;
    assign scl_rise  =  w_scl_cur & ~scl_prev_q;
    assign scl_fall  = ~w_scl_cur &  scl_prev_q;
    // SCL must be high on both samples so an SDA change coincident with
    // an SCL edge is never mistaken for a bus condition.
    assign start_det = ~w_sda_cur &  sda_prev_q & w_scl_cur & scl_prev_q;
    assign stop_det  =  w_sda_cur & ~sda_prev_q & w_scl_cur & scl_prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_target_rx
// Description : I2C target (responder). Detects START/STOP, matches a 7-bit
//               address, ACKs it and deserialises write bytes into a
//               single-cycle valid stream.
// Ports       : clk, reset        - system clock (>= 8x SCL), async reset
//               scl_in, sda_in    - bus pins
//               sda_out           - 0 pulls SDA low, 1 releases
//               rx_data/rx_valid/rx_first - received byte stream
//               frame_start/frame_stop    - bus condition pulses
//               busy, byte_count  - transaction status
//               tx_data, tx_req   - read data path (optional)
// Options     : I2C_TARGET_READ_EN - adds read transfers (tx_data/tx_req).
//               Undefined: read addresses are not acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_rx
    import I2cTargetPackage::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_first,
    output logic        frame_start,
    output logic        frame_stop,
    output logic        busy,
    output logic [15:0] byte_count
`ifdef I2C_TARGET_READ_EN
    ,
    input  logic [7:0]  tx_data,
    output logic        tx_req
`endif
);

    logic scl_hi, sda_hi, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_hi    (scl_hi),
        .sda_hi    (sda_hi),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    I2cTargetState_enum state_q, state_d;
    // Seven stored bits: the eighth bit completes the byte straight from
    // the line, and on reads the MSB goes to the pin at load time.
    logic [6:0]  shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    // ACK slot phase: 0 = waiting for the fall that starts the slot,
    // 1 = slot in progress, next fall ends it.
    logic        ack_drv_q, ack_drv_d;
    logic        sda_out_q, sda_out_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_first_q, rx_first_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_stop_q, frame_stop_d;
    logic        busy_q, busy_d;
    logic [15:0] byte_count_q, byte_count_d;
`ifdef I2C_TARGET_READ_EN
    logic        rd_q, rd_d;
    logic        tx_req_q, tx_req_d;
`endif

    logic       w_bit_tick;
    logic [7:0] w_byte;
    logic       w_addr_match;
    logic       w_is_read;

    assign w_bit_tick   = scl_rise & scl_hi;
    assign w_byte       = {shreg_q, sda_hi};
    assign w_addr_match = (w_byte[7:1] == TARGET_ADDR);
    assign w_is_read    = (w_byte[0] == I2C_RW_READ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            ack_drv_q     <= 1'b0;
            sda_out_q     <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_first_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_stop_q  <= 1'b0;
            busy_q        <= 1'b0;
            byte_count_q  <= '0;
`ifdef I2C_TARGET_READ_EN
            rd_q          <= 1'b0;
            tx_req_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            ack_drv_q     <= ack_drv_d;
            sda_out_q     <= sda_out_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_first_q    <= rx_first_d;
            frame_start_q <= frame_start_d;
            frame_stop_q  <= frame_stop_d;
            busy_q        <= busy_d;
            byte_count_q  <= byte_count_d;
`ifdef I2C_TARGET_READ_EN
            rd_q          <= rd_d;
            tx_req_q      <= tx_req_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        ack_drv_d     = ack_drv_q;
        sda_out_d     = sda_out_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_first_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_stop_d  = 1'b0;
        busy_d        = busy_q;
        byte_count_d  = byte_count_q;
`ifdef I2C_TARGET_READ_EN
        rd_d          = rd_q;
        tx_req_d      = 1'b0;
`endif

        // Bus conditions override any bit activity; a partial byte is
        // simply abandoned.
        if ((state_q != IDLE) && stop_det) begin
            state_d      = IDLE;
            sda_out_d    = 1'b1;
            busy_d       = 1'b0;
            frame_stop_d = busy_q;
        end else if (start_det) begin
            state_d       = ADDR;
            sda_out_d     = 1'b1;
            busy_d        = 1'b0;
            frame_start_d = 1'b1;
            bitcnt_d      = '0;
            ack_drv_d     = 1'b0;
            byte_count_d  = '0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (w_bit_tick) begin
                        shreg_d  = w_byte[6:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == LAST_BIT_IDX) begin
                            ack_drv_d = 1'b0;
                            if (w_addr_match && !w_is_read) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
`ifdef I2C_TARGET_READ_EN
                                rd_d    = 1'b0;
`endif
                            end
`ifdef I2C_TARGET_READ_EN
                            else if (w_addr_match) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                                rd_d    = 1'b1;
                            end
`endif
                            else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end

                ADDR_ACK, WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            sda_out_d = 1'b0;
                            ack_drv_d = 1'b1;
                        end else begin
                            ack_drv_d = 1'b0;
                            bitcnt_d  = '0;
`ifdef I2C_TARGET_READ_EN
                            if (rd_q) begin
                                // The fall ending the address ACK also
                                // launches the first read bit.
                                state_d   = READ_BYTE;
                                shreg_d   = tx_data[6:0];
                                sda_out_d = tx_data[7];
                                tx_req_d  = 1'b1;
                            end else
`endif
                            begin
                                state_d   = WRITE_BYTE;
                                sda_out_d = 1'b1;
                            end
                        end
                    end
                end

                WRITE_BYTE: begin
                    if (w_bit_tick) begin
                        shreg_d  = w_byte[6:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == LAST_BIT_IDX) begin
                            rx_data_d    = w_byte;
                            rx_valid_d   = 1'b1;
                            rx_first_d   = (byte_count_q == 16'd0);
                            byte_count_d = byte_count_q + 16'd1;
                            state_d      = WRITE_ACK;
                            ack_drv_d    = 1'b0;
                        end
                    end
                end

`ifdef I2C_TARGET_READ_EN
                READ_BYTE: begin
                    if (scl_fall) begin
                        if (bitcnt_q == LAST_BIT_IDX) begin
                            sda_out_d    = 1'b1;
                            state_d      = READ_ACK;
                            ack_drv_d    = 1'b0;
                            bitcnt_d     = '0;
                            byte_count_d = byte_count_q + 16'd1;
                        end else begin
                            sda_out_d = shreg_q[6];
                            shreg_d   = {shreg_q[5:0], 1'b0};
                            bitcnt_d  = bitcnt_q + 3'd1;
                        end
                    end
                end

                READ_ACK: begin
                    // ack_drv_q marks that the master ACKed; the next byte
                    // starts on the fall closing the ACK clock.
                    if (ack_drv_q) begin
                        if (scl_fall) begin
                            state_d   = READ_BYTE;
                            ack_drv_d = 1'b0;
                            bitcnt_d  = '0;
                            shreg_d   = tx_data[6:0];
                            sda_out_d = tx_data[7];
                            tx_req_d  = 1'b1;
                        end
                    end else if (w_bit_tick) begin
                        if (sda_hi) begin
                            state_d = IGNORE;
                        end else begin
                            ack_drv_d = 1'b1;
                        end
                    end
                end
`endif

                IDLE, IGNORE: begin
                end

                default: begin
                    state_d   = IDLE;
                    sda_out_d = 1'b1;
                end
            endcase
        end
    end

    assign sda_out     = sda_out_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_first    = rx_first_q;
    assign frame_start = frame_start_q;
    assign frame_stop  = frame_stop_q;
    assign busy        = busy_q;
    assign byte_count  = byte_count_q;
`ifdef I2C_TARGET_READ_EN
    assign tx_req      = tx_req_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_target_rx
// Description : Self-checking bench for i2c_target_rx. A bit-level I2C
//               master drives an open-drain bus model; received bytes are
//               checked against a scoreboard queue. Honours
//               I2C_TARGET_READ_EN for the read-path sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_out;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_first;
    logic        frame_start;
    logic        frame_stop;
    logic        busy;
    logic [15:0] byte_count;
`ifdef I2C_TARGET_READ_EN
    logic [7:0]  tx_data;
    logic        tx_req;
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    assign sda_line = sda_m & sda_out;

    always #5 clk = ~clk;

    i2c_target_rx #(
        .TARGET_ADDR (7'h3C),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl_m),
        .sda_in      (sda_line),
        .sda_out     (sda_out),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_first    (rx_first),
        .frame_start (frame_start),
        .frame_stop  (frame_stop),
        .busy        (busy),
        .byte_count  (byte_count)
`ifdef I2C_TARGET_READ_EN
        ,
        .tx_data     (tx_data),
        .tx_req      (tx_req)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_stop = 0;
    int n_rx = 0;
    int n_txreq = 0;
    int qp = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } rx_exp_t;

    rx_exp_t sb_q[$];
    rx_exp_t mon_e;

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nbytes;
        int         qp;
        bit         exp_ack;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit timing: entered with SCL low for qp clocks; data set, SCL high
    // for 2*qp, line sampled mid-high, SCL low again for qp.
    task automatic send_bit(input logic b, input bit glitch, output logic smp);
        if (glitch) begin
            sda_m = ~sda_m;
            wait_clk(1);
            sda_m = ~sda_m;
            wait_clk(1);
        end
        sda_m = b;
        wait_clk(qp);
        scl_m = 1'b1;
        wait_clk(qp);
        smp = sda_line;
        wait_clk(qp);
        scl_m = 1'b0;
        wait_clk(qp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch, s);
        send_bit(1'b1, 1'b0, s);
        acked = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        send_bit(mack, 1'b0, s);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0;
        wait_clk(2 * qp);
        scl_m = 1'b0;
        wait_clk(qp);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1;
        wait_clk(qp);
        scl_m = 1'b1;
        wait_clk(qp);
        sda_m = 1'b0;
        wait_clk(qp);
        scl_m = 1'b0;
        wait_clk(qp);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(qp);
        scl_m = 1'b1;
        wait_clk(qp);
        sda_m = 1'b1;
        wait_clk(2 * qp);
    endtask

    // Output monitor and scoreboard pop.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_start) n_start++;
            if (frame_stop)  n_stop++;
`ifdef I2C_TARGET_READ_EN
            if (tx_req)      n_txreq++;
`endif
            if (rx_valid) begin
                n_rx++;
                if (sb_q.size() == 0) begin
                    check("rx_unexpected", {24'd0, rx_data}, 32'h100);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
                    check("rx_first", {31'd0, rx_first}, {31'd0, mon_e.first});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values();
        check("rst_sda_out",     {31'd0, sda_out},     32'd1);
        check("rst_rx_data",     {24'd0, rx_data},     32'd0);
        check("rst_rx_valid",    {31'd0, rx_valid},    32'd0);
        check("rst_rx_first",    {31'd0, rx_first},    32'd0);
        check("rst_frame_start", {31'd0, frame_start}, 32'd0);
        check("rst_frame_stop",  {31'd0, frame_stop},  32'd0);
        check("rst_busy",        {31'd0, busy},        32'd0);
        check("rst_byte_count",  {16'd0, byte_count},  32'd0);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] db;
        logic [7:0] rd;
        bit         is_wr;
        int         s0, p0, r0, t0, k;

        vecs[0] = '{8'h78, 8'h00, 8'hAF, 2, 4, 1'b1};
        vecs[1] = '{8'h7A, 8'h55, 8'h00, 1, 4, 1'b0};
        vecs[2] = '{8'h78, 8'hFF, 8'h01, 2, 2, 1'b1};
        vecs[3] = '{8'h78, 8'h3C, 8'h00, 1, 8, 1'b1};
        vecs[4] = '{8'h20, 8'h81, 8'h00, 1, 4, 1'b0};
        vecs[5] = '{8'h79, 8'h00, 8'h00, 0, 4, RD_EN};

`ifdef I2C_TARGET_READ_EN
        tx_data = 8'hA5;
`endif
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(5);
        check_reset_values();
        reset = 1'b0;
        wait_clk(5);

        // Table-driven transactions.
        for (int v = 0; v < 6; v++) begin
            qp = vecs[v].qp;
            s0 = n_start;
            p0 = n_stop;
            i2c_start();
            send_byte(vecs[v].addr_byte, 1'b0, ack);
            check("addr_ack", {31'd0, ack}, {31'd0, vecs[v].exp_ack});
            check("busy_after_addr", {31'd0, busy}, {31'd0, vecs[v].exp_ack});
            is_wr = vecs[v].exp_ack && !vecs[v].addr_byte[0];
            for (int j = 0; j < vecs[v].nbytes; j++) begin
                db = (j == 0) ? vecs[v].d0 : vecs[v].d1;
                if (is_wr) sb_q.push_back('{data: db, first: (j == 0)});
                send_byte(db, 1'b0, ack);
                check("data_ack", {31'd0, ack}, {31'd0, is_wr});
            end
            check("byte_count", {16'd0, byte_count}, is_wr ? vecs[v].nbytes : 0);
            i2c_stop();
            check("busy_after_stop", {31'd0, busy}, 32'd0);
            check("frame_start_cnt", n_start - s0, 32'd1);
            check("frame_stop_cnt", n_stop - p0, {31'd0, vecs[v].exp_ack});
            check("sb_drained", sb_q.size(), 32'd0);
        end

        // Partial byte then repeated START: partial data dropped.
        qp = 4;
        s0 = n_start;
        p0 = n_stop;
        r0 = n_rx;
        i2c_start();
        send_byte(8'h78, 1'b0, ack);
        check("rs_addr_ack1", {31'd0, ack}, 32'd1);
        send_bit(1'b1, 1'b0, s);
        send_bit(1'b0, 1'b0, s);
        send_bit(1'b0, 1'b0, s);
        send_bit(1'b1, 1'b0, s);
        i2c_rstart();
        send_byte(8'h78, 1'b0, ack);
        check("rs_addr_ack2", {31'd0, ack}, 32'd1);
        sb_q.push_back('{data: 8'h12, first: 1'b1});
        send_byte(8'h12, 1'b0, ack);
        check("rs_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("rs_frame_start_cnt", n_start - s0, 32'd2);
        check("rs_frame_stop_cnt", n_stop - p0, 32'd1);
        check("rs_rx_cnt", n_rx - r0, 32'd1);
        check("rs_sb_drained", sb_q.size(), 32'd0);

        // Reset asserted while the target is pulling SDA low for an ACK.
        qp = 4;
        i2c_start();
        send_byte(8'h78, 1'b0, ack);
        check("rr_addr_ack", {31'd0, ack}, 32'd1);
        sb_q.push_back('{data: 8'h33, first: 1'b1});
        db = 8'h33;
        for (int i = 7; i >= 0; i--) send_bit(db[i], 1'b0, s);
        k = 0;
        while (sda_out !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rr_ack_low", {31'd0, sda_out}, 32'd0);
        check("rr_count_before", {16'd0, byte_count}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rr_sda_async_release", {31'd0, sda_out}, 32'd1);
        @(negedge clk);
        check_reset_values();
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(4);
        p0 = n_stop;
        i2c_start();
        send_byte(8'h78, 1'b0, ack);
        check("rr_post_addr_ack", {31'd0, ack}, 32'd1);
        sb_q.push_back('{data: 8'h42, first: 1'b1});
        send_byte(8'h42, 1'b0, ack);
        check("rr_post_data_ack", {31'd0, ack}, 32'd1);
        check("rr_post_count", {16'd0, byte_count}, 32'd1);
        i2c_stop();
        check("rr_post_stop", n_stop - p0, 32'd1);
        check("rr_sb_drained", sb_q.size(), 32'd0);

        // SDA glitches while SCL low, SCL at clk/8.
        qp = 2;
        s0 = n_start;
        p0 = n_stop;
        r0 = n_rx;
        i2c_start();
        send_byte(8'h78, 1'b1, ack);
        check("gl_addr_ack", {31'd0, ack}, 32'd1);
        sb_q.push_back('{data: 8'hC3, first: 1'b1});
        send_byte(8'hC3, 1'b1, ack);
        check("gl_data_ack0", {31'd0, ack}, 32'd1);
        sb_q.push_back('{data: 8'h5A, first: 1'b0});
        send_byte(8'h5A, 1'b1, ack);
        check("gl_data_ack1", {31'd0, ack}, 32'd1);
        check("gl_count", {16'd0, byte_count}, 32'd2);
        i2c_stop();
        check("gl_frame_start_cnt", n_start - s0, 32'd1);
        check("gl_frame_stop_cnt", n_stop - p0, 32'd1);
        check("gl_rx_cnt", n_rx - r0, 32'd2);
        check("gl_sb_drained", sb_q.size(), 32'd0);

`ifdef I2C_TARGET_READ_EN
        // Read: master ACKs first byte, NACKs second, then target ignores.
        qp = 4;
        t0 = n_txreq;
        p0 = n_stop;
        i2c_start();
        send_byte(8'h79, 1'b0, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd1);
        recv_byte(1'b0, rd);
        check("rd_byte0", {24'd0, rd}, 32'hA5);
        recv_byte(1'b1, rd);
        check("rd_byte1", {24'd0, rd}, 32'hA5);
        check("rd_txreq_cnt", n_txreq - t0, 32'd2);
        check("rd_count", {16'd0, byte_count}, 32'd2);
        recv_byte(1'b1, rd);
        check("rd_ignored", {24'd0, rd}, 32'hFF);
        check("rd_txreq_after_nack", n_txreq - t0, 32'd2);
        i2c_stop();
        check("rd_busy_after_stop", {31'd0, busy}, 32'd0);
        check("rd_frame_stop_cnt", n_stop - p0, 32'd1);
`else
        t0 = 0;
        rd = 8'h00;
`endif

        wait_clk(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
